// File: rtl/srambank_access_ctrl.sv
// Request-side controller for one synchronous SRAM bank: issues registered bank strobes,
// performs half-masked writes as read-modify-write, and buffers read data in a small FIFO.
module srambank_access_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 18,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] wd,
  output logic              banksel,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] dataout,
  output logic [1:0]        dbg_state
);
  localparam int HALF  = DATA_W / 2;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1) + 1;

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
  // valid never waits on ready, and the FIFO head stays stable while rsp_valid & !rsp_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, RMW_RD = 2'd1, RMW_MRG = 2'd2} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] lat_addr, addr_nxt;
  logic [DATA_W-1:0] lat_wdata, wd_nxt, merged;
  logic [1:0]        lat_mask;
  logic              read_nxt, write_nxt, rd_host, rd_host_nxt, cap, latch_rmw;
  logic              accept, push, pop;
  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, outstanding;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover FIFO entries plus host reads still travelling through the bank.
  assign outstanding = count + CNT_W'(rd_host) + CNT_W'(cap);
  assign req_ready   = (state == IDLE) && (outstanding < CNT_W'(RSP_DEPTH));
  assign accept      = req_valid && req_ready;
  assign merged      = {lat_mask[1] ? lat_wdata[DATA_W-1:HALF] : dataout[DATA_W-1:HALF],
                        lat_mask[0] ? lat_wdata[HALF-1:0]      : dataout[HALF-1:0]};
  assign dbg_state   = state;

  always_comb begin
    state_nxt   = state;
    addr_nxt    = ADDRESS;
    wd_nxt      = wd;
    read_nxt    = 1'b0;
    write_nxt   = 1'b0;
    rd_host_nxt = 1'b0;
    latch_rmw   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!req_write) begin
            addr_nxt    = req_addr;
            read_nxt    = 1'b1;
            rd_host_nxt = 1'b1;
          end else if (req_wmask == 2'b11) begin
            addr_nxt  = req_addr;
            wd_nxt    = req_wdata;
            write_nxt = 1'b1;
          end else if (req_wmask != 2'b00) begin
            addr_nxt  = req_addr;
            read_nxt  = 1'b1;
            latch_rmw = 1'b1;
            state_nxt = RMW_RD;
          end
        end
      end
      RMW_RD:  state_nxt = RMW_MRG;
      RMW_MRG: begin
        addr_nxt  = lat_addr;
        wd_nxt    = merged;
        write_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ADDRESS   <= '0;
      wd        <= '0;
      read      <= 1'b0;
      write     <= 1'b0;
      banksel   <= 1'b0;
      rd_host   <= 1'b0;
      cap       <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_mask  <= '0;
    end else begin
      state   <= state_nxt;
      ADDRESS <= addr_nxt;
      wd      <= wd_nxt;
      read    <= read_nxt;
      write   <= write_nxt;
      banksel <= read_nxt | write_nxt;
      rd_host <= rd_host_nxt;
      cap     <= rd_host;
      if (latch_rmw) begin
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_mask  <= req_wmask;
      end
    end
  end

  // dataout is captured the cycle after a host read strobe; RMW reads never set rd_host.
  assign push      = cap;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (count != '0);
  assign rsp_rdata = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= dataout;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CNT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_srambank_access_ctrl.sv
// Directed and random checks of srambank_access_ctrl against a behavioural bank and a
// reference memory; read responses are scored through an expected-data queue.
module tb_srambank_access_ctrl;
  localparam int AW = 9;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_wmask = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ADDRESS;
  logic [DW-1:0] wd, dataout;
  logic          banksel, read, write;
  logic [1:0]    dbg_state;

  logic [DW-1:0] bank_mem [512];
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] exp_q [$];
  int            total = 0;
  int            bad = 0;
  bit            rand_rsp = 1'b0;

  always #5 clk = ~clk;

  srambank_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ADDRESS(ADDRESS), .wd(wd), .banksel(banksel), .read(read), .write(write),
    .dataout(dataout), .dbg_state(dbg_state)
  );

  // Behavioural 512x18 bank: dataout holds until the next read.
  always @(posedge clk) begin
    if (banksel && write) bank_mem[ADDRESS] <= wd;
    if (banksel && read) dataout <= bank_mem[ADDRESS];
  end

  function automatic logic [DW-1:0] rmw_ref(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [1:0] m);
    logic [DW-1:0] r;
    r = old;
    if (m[1]) r[17:9] = nw[17:9];
    if (m[0]) r[8:0] = nw[8:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score outputs, update the model on accepted requests, advance past the edge.
  task automatic tick();
    logic [DW-1:0] e;
    if (rand_rsp) rsp_ready = 1'($urandom_range(0, 1));
    chk("strobe_excl", 32'(read && write), 32'd0);
    chk("banksel_match", 32'(banksel), 32'(read | write));
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e));
      end
    end
    if (req_valid && req_ready) begin
      if (!req_write) exp_q.push_back(ref_mem[req_addr]);
      else ref_mem[req_addr] = rmw_ref(ref_mem[req_addr], req_wdata, req_wmask);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [1:0] m);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    chk("accept_wait", 32'(req_ready), 32'd1);
    if (req_ready) tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] saved;
    int acc;
    logic hs;

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_address", 32'(ADDRESS), 32'd0);
    chk("rst_wd", 32'(wd), 32'd0);
    chk("rst_banksel", 32'(banksel), 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Full write then read-back with 2-cycle latency
    rsp_ready = 1'b1;
    send(1'b1, 9'd5, 18'h2AAAA, 2'b11);
    chk("wr_strobe", 32'(write), 32'd1);
    chk("wr_read_low", 32'(read), 32'd0);
    chk("wr_addr", 32'(ADDRESS), 32'd5);
    chk("wr_wd", 32'(wd), 32'h2AAAA);
    send(1'b0, 9'd5, '0, 2'b00);
    chk("rd_strobe", 32'(read), 32'd1);
    chk("rd_addr", 32'(ADDRESS), 32'd5);
    chk("rd_lat0", 32'(rsp_valid), 32'd0);
    tick();
    chk("rd_lat1", 32'(rsp_valid), 32'd0);
    tick();
    chk("rd_lat2", 32'(rsp_valid), 32'd1);
    chk("rd_data", 32'(rsp_rdata), 32'h2AAAA);
    drain();

    // Lower-half masked write as RMW
    send(1'b1, 9'd9, 18'h3FFFF, 2'b11);
    send(1'b1, 9'd9, 18'h00000, 2'b01);
    chk("rmw_rd_strobe", 32'(read), 32'd1);
    chk("rmw_rd_addr", 32'(ADDRESS), 32'd9);
    chk("rmw_ready_0", 32'(req_ready), 32'd0);
    chk("rmw_state_rd", 32'(dbg_state), 32'd1);
    tick();
    chk("rmw_ready_1", 32'(req_ready), 32'd0);
    chk("rmw_state_mrg", 32'(dbg_state), 32'd2);
    chk("rmw_no_strobe", 32'(banksel), 32'd0);
    tick();
    chk("rmw_wr_strobe", 32'(write), 32'd1);
    chk("rmw_wr_data", 32'(wd), 32'h3FE00);
    chk("rmw_wr_addr", 32'(ADDRESS), 32'd9);
    chk("rmw_ready_back", 32'(req_ready), 32'd1);
    send(1'b0, 9'd9, '0, 2'b00);
    drain();

    // Backpressure: only RSP_DEPTH reads accepted while rsp_ready is low
    for (int i = 0; i < 4; i++) send(1'b1, 9'(i), 18'(i + 1), 2'b11);
    tick();
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = (acc < 4);
      req_write = 1'b0;
      req_addr  = 9'(acc);
      hs = req_valid && req_ready;
      tick();
      if (hs) acc++;
    end
    req_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    chk("bp_no_strobe", 32'(banksel), 32'd0);
    chk("bp_head", 32'(rsp_rdata), 32'd1);
    rsp_ready = 1'b1;
    send(1'b0, 9'd2, '0, 2'b00);
    send(1'b0, 9'd3, '0, 2'b00);
    drain();
    tick();
    chk("bp_empty", 32'(rsp_valid), 32'd0);

    // Mask 00 write performs no bank access
    send(1'b1, 9'd7, 18'h12345, 2'b11);
    send(1'b1, 9'd7, 18'h3FFFF, 2'b00);
    chk("m00_no_bank", 32'(banksel), 32'd0);
    tick();
    chk("m00_no_bank2", 32'(banksel), 32'd0);
    send(1'b0, 9'd7, '0, 2'b00);
    tick();
    tick();
    chk("m00_data", 32'(rsp_rdata), 32'h12345);
    drain();

    // Reset during RMW_MRG abandons the merge write
    send(1'b1, 9'd11, 18'h0ABCD, 2'b11);
    saved = 18'h0ABCD;
    send(1'b1, 9'd11, 18'h3FFFF, 2'b10);
    tick();
    chk("rstm_state", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rstm_write", 32'(write), 32'd0);
    chk("rstm_banksel", 32'(banksel), 32'd0);
    chk("rstm_address", 32'(ADDRESS), 32'd0);
    chk("rstm_state0", 32'(dbg_state), 32'd0);
    ref_mem[11] = saved;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rstm_ready", 32'(req_ready), 32'd1);
    chk("rstm_no_write", 32'(write), 32'd0);
    send(1'b0, 9'd11, '0, 2'b00);
    drain();

    // Random mix over a preloaded window with random response backpressure
    for (int i = 0; i < 16; i++) send(1'b1, 9'(i), 18'($urandom()), 2'b11);
    rand_rsp = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) == 0)
        send(1'b0, 9'($urandom_range(0, 15)), '0, 2'b00);
      else
        send(1'b1, 9'($urandom_range(0, 15)), 18'($urandom()), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_rsp = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
